// File: rtl/bira_engine.sv
// ---------------------------------------------------------------------------
// bira_engine -- built-in redundancy analysis for a banked memory array.
//
// Faults reported by BIST are collected into two CAMs. A fault that shares
// neither row nor column with a stored pivot becomes a new pivot. A fault
// that shares a row or column with a pivot is stored as a non-pivot. Exact
// repeats are dropped. When BIST ends, every row/column assignment of the
// pivots is tried in increasing mask order. The first assignment that fits
// the spare budget and covers all non-pivots is reported as one word per
// pivot.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin fault collection (from IDLE or DONE)
//   fault_detect      fault address below is valid this cycle
//   row_add_in, col_add_in, bank_in   fault address
//   test_end          BIST finished
//   early_term        unrepairable during collection; held until start/rst
//   sol_valid/sol_ready/sol_data     repair words {is_col, bank, addr}
//   done, repair      analysis complete / repairable (valid while done)
//   state_dbg         current FSM state, for observation only
//
// Handshake: a solution word moves on a rising edge where sol_valid and
// sol_ready are both 1. While sol_valid is 1 and sol_ready is 0, sol_data
// holds its value. sol_valid does not drop until the word has moved.
// ---------------------------------------------------------------------------
module bira_engine #(
  parameter int ROW_W    = 10,
  parameter int COL_W    = 10,
  parameter int BANK_W   = 2,
  parameter int R_SPARES = 2,
  parameter int C_SPARES = 2,
  parameter int NPCAM    = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         fault_detect,
  input  logic [ROW_W-1:0]                             row_add_in,
  input  logic [COL_W-1:0]                             col_add_in,
  input  logic [BANK_W-1:0]                            bank_in,
  input  logic                                         test_end,
  output logic                                         early_term,
  output logic                                         sol_valid,
  input  logic                                         sol_ready,
  output logic [BANK_W+((ROW_W>COL_W)?ROW_W:COL_W):0]  sol_data,
  output logic                                         done,
  output logic                                         repair,
  output logic [2:0]                                   state_dbg
);

  localparam int AW   = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int SW   = 1 + BANK_W + AW;
  localparam int PCAM = R_SPARES + C_SPARES;
  localparam int PCW  = $clog2(PCAM + 1);
  localparam int NCW  = $clog2(NPCAM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ANALYZE,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state;
  assign state_dbg = state;

  // Pivot CAM. Entries fill from index 0 upward, so the valid bits are
  // always a contiguous block at the low end.
  logic [PCAM-1:0]   pv_valid;
  logic [BANK_W-1:0] pv_bank [PCAM];
  logic [ROW_W-1:0]  pv_row  [PCAM];
  logic [COL_W-1:0]  pv_col  [PCAM];
  logic [PCW-1:0]    p_cnt;

  // Non-pivot CAM
  logic [NPCAM-1:0]  np_valid;
  logic [BANK_W-1:0] np_bank [NPCAM];
  logic [ROW_W-1:0]  np_row  [NPCAM];
  logic [COL_W-1:0]  np_col  [NPCAM];
  logic [NCW-1:0]    np_cnt;

  logic [PCAM-1:0]   mask;      // candidate under evaluation
  logic [PCAM-1:0]   sol_mask;  // accepted candidate
  logic [PCW-1:0]    rep_idx;   // pivot whose word is on sol_data

  // ---------------- fault classification ----------------
  logic           exact_hit, rc_hit;
  logic           to_pv, to_np, pv_full, np_full, overflow;
  logic [PCW-1:0] p_cnt_after;

  always_comb begin
    exact_hit = 1'b0;
    rc_hit    = 1'b0;
    for (int i = 0; i < PCAM; i++) begin
      if (pv_valid[i] && pv_bank[i] == bank_in) begin
        if (pv_row[i] == row_add_in && pv_col[i] == col_add_in) exact_hit = 1'b1;
        if (pv_row[i] == row_add_in || pv_col[i] == col_add_in) rc_hit = 1'b1;
      end
    end
    for (int j = 0; j < NPCAM; j++) begin
      if (np_valid[j] && np_bank[j] == bank_in &&
          np_row[j] == row_add_in && np_col[j] == col_add_in) exact_hit = 1'b1;
    end
  end

  assign pv_full     = (p_cnt == PCW'(PCAM));
  assign np_full     = (np_cnt == NCW'(NPCAM));
  assign to_np       = fault_detect && !exact_hit && rc_hit;
  assign to_pv       = fault_detect && !exact_hit && !rc_hit;
  assign overflow    = (to_np && np_full) || (to_pv && pv_full);
  // Only used when there is no overflow, so the increment always fits.
  assign p_cnt_after = p_cnt + PCW'(to_pv);

  // ---------------- candidate evaluation ----------------
  int               n_rows, n_cols;
  logic [NPCAM-1:0] np_cov;
  logic             cand_ok;

  always_comb begin
    n_rows = 0;
    n_cols = 0;
    np_cov = '0;
    for (int i = 0; i < PCAM; i++) begin
      if (pv_valid[i]) begin
        if (mask[i]) n_rows = n_rows + 1;
        else         n_cols = n_cols + 1;
      end
    end
    // A non-pivot is covered by a row spare on a pivot in its row, or by a
    // column spare on a pivot in its column, within the same bank.
    for (int j = 0; j < NPCAM; j++) begin
      if (!np_valid[j]) begin
        np_cov[j] = 1'b1;
      end else begin
        for (int i = 0; i < PCAM; i++) begin
          if (pv_valid[i] && pv_bank[i] == np_bank[j] &&
              (mask[i] ? (pv_row[i] == np_row[j]) : (pv_col[i] == np_col[j])))
            np_cov[j] = 1'b1;
        end
      end
    end
    cand_ok = (&np_cov) && (n_rows <= R_SPARES) && (n_cols <= C_SPARES);
  end

  // ---------------- solution word selection ----------------
  // In ANALYZE this picks word 0 of the candidate being accepted. In REPORT
  // it picks the word after the one currently presented.
  logic [PCW-1:0]  sel_idx;
  logic [PCAM-1:0] sel_mask;
  logic [SW-1:0]   word_sel;

  always_comb begin
    sel_idx  = (state == S_ANALYZE) ? '0 : rep_idx + PCW'(1);
    sel_mask = (state == S_ANALYZE) ? mask : sol_mask;
    word_sel = '0;
    for (int i = 0; i < PCAM; i++) begin
      if (PCW'(i) == sel_idx) begin
        if (sel_mask[i]) word_sel = {1'b0, pv_bank[i], AW'(pv_row[i])};
        else             word_sel = {1'b1, pv_bank[i], AW'(pv_col[i])};
      end
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pv_valid   <= '0;
      np_valid   <= '0;
      p_cnt      <= '0;
      np_cnt     <= '0;
      mask       <= '0;
      sol_mask   <= '0;
      rep_idx    <= '0;
      early_term <= 1'b0;
      sol_valid  <= 1'b0;
      sol_data   <= '0;
      done       <= 1'b0;
      repair     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pv_valid   <= '0;
            np_valid   <= '0;
            p_cnt      <= '0;
            np_cnt     <= '0;
            early_term <= 1'b0;
            done       <= 1'b0;
            repair     <= 1'b0;
            state      <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (overflow) begin
            early_term <= 1'b1;
            done       <= 1'b1;
            repair     <= 1'b0;
            state      <= S_DONE;
          end else begin
            if (to_pv) begin
              for (int i = 0; i < PCAM; i++) begin
                if (PCW'(i) == p_cnt) begin
                  pv_valid[i] <= 1'b1;
                  pv_bank[i]  <= bank_in;
                  pv_row[i]   <= row_add_in;
                  pv_col[i]   <= col_add_in;
                end
              end
              p_cnt <= p_cnt + PCW'(1);
            end
            if (to_np) begin
              for (int j = 0; j < NPCAM; j++) begin
                if (NCW'(j) == np_cnt) begin
                  np_valid[j] <= 1'b1;
                  np_bank[j]  <= bank_in;
                  np_row[j]   <= row_add_in;
                  np_col[j]   <= col_add_in;
                end
              end
              np_cnt <= np_cnt + NCW'(1);
            end
            // A fault arriving with test_end is already counted here.
            if (test_end) begin
              if (p_cnt_after == '0) begin
                done   <= 1'b1;
                repair <= 1'b1;
                state  <= S_DONE;
              end else begin
                mask  <= '0;
                state <= S_ANALYZE;
              end
            end
          end
        end

        S_ANALYZE: begin
          if (cand_ok) begin
            sol_mask  <= mask;
            rep_idx   <= '0;
            sol_valid <= 1'b1;
            sol_data  <= word_sel;
            state     <= S_REPORT;
          end else if (mask == pv_valid) begin
            // All-ones over the P pivots is the final candidate.
            done   <= 1'b1;
            repair <= 1'b0;
            state  <= S_DONE;
          end else begin
            mask <= mask + PCAM'(1);
          end
        end

        S_REPORT: begin
          if (sol_ready) begin
            if (rep_idx + PCW'(1) == p_cnt) begin
              sol_valid <= 1'b0;
              sol_data  <= '0;
              done      <= 1'b1;
              repair    <= 1'b1;
              state     <= S_DONE;
            end else begin
              rep_idx  <= rep_idx + PCW'(1);
              sol_data <= word_sel;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bira_engine.sv
// ---------------------------------------------------------------------------
// tb_bira_engine -- bench for bira_engine with directed and random fault sets
// checked against a list-based repair model.
// ---------------------------------------------------------------------------
module tb_bira_engine;

  localparam int ROW_W    = 10;
  localparam int COL_W    = 10;
  localparam int BANK_W   = 2;
  localparam int R_SPARES = 2;
  localparam int C_SPARES = 2;
  localparam int NPCAM    = 8;
  localparam int PCAM     = R_SPARES + C_SPARES;
  localparam int AW       = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int SW       = 1 + BANK_W + AW;
  localparam int LAT_MAX  = (1 << PCAM) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              fault_detect = 1'b0;
  logic [ROW_W-1:0]  row_add_in = '0;
  logic [COL_W-1:0]  col_add_in = '0;
  logic [BANK_W-1:0] bank_in = '0;
  logic              test_end = 1'b0;
  logic              early_term;
  logic              sol_valid;
  logic              sol_ready = 1'b0;
  logic [SW-1:0]     sol_data;
  logic              done;
  logic              repair;
  logic [2:0]        state_dbg;

  bira_engine #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W),
    .R_SPARES(R_SPARES), .C_SPARES(C_SPARES), .NPCAM(NPCAM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fault_detect(fault_detect),
    .row_add_in(row_add_in), .col_add_in(col_add_in), .bank_in(bank_in),
    .test_end(test_end), .early_term(early_term), .sol_valid(sol_valid),
    .sol_ready(sol_ready), .sol_data(sol_data), .done(done), .repair(repair),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  typedef struct { int b; int r; int c; } ent_t;
  ent_t        m_piv[$];
  ent_t        m_np[$];
  bit          m_et;
  logic [SW-1:0] exp_q[$];

  int fb[16], fr[16], fc[16];

  function automatic logic [SW-1:0] mk_word(input bit is_col, input int b, input int a);
    int v;
    v = (int'(is_col) << (BANK_W + AW)) + (b << AW) + a;
    return SW'(v);
  endfunction

  function automatic void model_fault(input int b, input int r, input int c);
    bit shares;
    ent_t e;
    if (m_et) return;
    foreach (m_piv[i]) if (m_piv[i].b == b && m_piv[i].r == r && m_piv[i].c == c) return;
    foreach (m_np[i])  if (m_np[i].b == b && m_np[i].r == r && m_np[i].c == c) return;
    shares = 0;
    foreach (m_piv[i]) if (m_piv[i].b == b && (m_piv[i].r == r || m_piv[i].c == c)) shares = 1;
    e.b = b; e.r = r; e.c = c;
    if (shares) begin
      if (m_np.size() == NPCAM) m_et = 1;
      else m_np.push_back(e);
    end else begin
      if (m_piv.size() == PCAM) m_et = 1;
      else m_piv.push_back(e);
    end
  endfunction

  // Tries all row/column assignments, lowest mask first; fills exp_q.
  function automatic bit model_analyze();
    int p;
    p = m_piv.size();
    for (int m = 0; m < (1 << p); m++) begin
      int nr;
      bit ok;
      nr = $countones(m);
      if (nr > R_SPARES || (p - nr) > C_SPARES) continue;
      ok = 1;
      foreach (m_np[j]) begin
        bit cov;
        cov = 0;
        for (int i = 0; i < p; i++)
          if (m_piv[i].b == m_np[j].b &&
              (m[i] ? (m_piv[i].r == m_np[j].r) : (m_piv[i].c == m_np[j].c))) cov = 1;
        if (!cov) ok = 0;
      end
      if (ok) begin
        for (int i = 0; i < p; i++)
          exp_q.push_back(m[i] ? mk_word(0, m_piv[i].b, m_piv[i].r)
                               : mk_word(1, m_piv[i].b, m_piv[i].c));
        return 1;
      end
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_f(input int i, input int b, input int r, input int c);
    fb[i] = b; fr[i] = r; fc[i] = c;
  endtask

  // Starts a run, feeds n faults from fb/fr/fc, ends BIST (optionally in the
  // same cycle as the last fault) and checks the outcome against the model.
  task automatic run_case(input int n, input bit te_last, input string name);
    bit exp_rep;
    int k;
    bit hold;
    logic [SW-1:0] held, w;
    m_piv.delete(); m_np.delete(); exp_q.delete(); m_et = 0;
    pulse_start();
    n_checks++;
    if ({done, repair, early_term, sol_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL %s start_clear: done/repair/et/sv=%b required 0000", name,
               {done, repair, early_term, sol_valid});
    end
    for (int i = 0; i < n; i++) begin
      fault_detect = 1'b1;
      bank_in = BANK_W'(fb[i]); row_add_in = ROW_W'(fr[i]); col_add_in = COL_W'(fc[i]);
      test_end = (te_last && i == n - 1);
      model_fault(fb[i], fr[i], fc[i]);
      step();
      fault_detect = 1'b0;
      test_end = 1'b0;
      if (m_et) break;
    end
    if (m_et) begin
      for (int h = 0; h < 3; h++) begin
        n_checks++;
        if ({early_term, done, repair, sol_valid} !== 4'b1100) begin
          n_errors++;
          $display("FAIL %s early_term: et/done/repair/sv=%b required 1100 (cycle %0d)",
                   name, {early_term, done, repair, sol_valid}, h);
        end
        step();
      end
      return;
    end
    if (!te_last || n == 0) begin
      test_end = 1'b1;
      step();
      test_end = 1'b0;
    end
    exp_rep = model_analyze();
    k = 0;
    while (!sol_valid && !done && k < LAT_MAX + 2) begin
      step();
      k++;
    end
    n_checks++;
    if (k > LAT_MAX) begin
      n_errors++;
      $display("FAIL %s latency: %0d cycles required <= %0d", name, k, LAT_MAX);
    end
    hold = 0;
    held = '0;
    k = 0;
    while (sol_valid && !done && k < 400) begin
      sol_ready = ($urandom_range(0, 3) != 0);
      if (hold) begin
        n_checks++;
        if (sol_data !== held) begin
          n_errors++;
          $display("FAIL %s stable: sol_data=%h required %h", name, sol_data, held);
        end
      end
      if (sol_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL %s extra_word: sol_data=%h required none", name, sol_data);
        end else begin
          w = exp_q.pop_front();
          if (sol_data !== w) begin
            n_errors++;
            $display("FAIL %s word: sol_data=%h required %h", name, sol_data, w);
          end
        end
        hold = 0;
      end else begin
        hold = 1;
        held = sol_data;
      end
      step();
      k++;
    end
    sol_ready = 1'b0;
    n_checks++;
    if ({done, repair, early_term, sol_valid} !== {1'b1, exp_rep, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s result: done/repair/et/sv=%b required %b", name,
               {done, repair, early_term, sol_valid}, {1'b1, exp_rep, 2'b00});
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s words_left: %0d words not emitted required 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({early_term, sol_valid, done, repair} !== 4'b0000 || sol_data !== '0) begin
      n_errors++;
      $display("FAIL reset: et/sv/done/repair=%b sol_data=%h required 0000 / 0",
               {early_term, sol_valid, done, repair}, sol_data);
    end
  endtask

  task automatic test_ignore_idle();
    fault_detect = 1'b1; test_end = 1'b1;
    bank_in = 2'd1; row_add_in = 10'd4; col_add_in = 10'd4;
    step(); step();
    fault_detect = 1'b0; test_end = 1'b0;
    n_checks++;
    if ({done, repair, sol_valid, early_term} !== 4'b0000) begin
      n_errors++;
      $display("FAIL ignore_idle: done/repair/sv/et=%b required 0000",
               {done, repair, sol_valid, early_term});
    end
  endtask

  task automatic test_no_faults();
    run_case(0, 0, "no_faults");
  endtask

  task automatic test_single_row();
    set_f(0, 0, 5, 7); set_f(1, 0, 5, 9);
    run_case(2, 0, "single_row");
  endtask

  task automatic test_pivot_overflow();
    for (int i = 0; i < 5; i++) set_f(i, 0, 10 + i, 20 + i);
    run_case(5, 0, "pivot_overflow");
  endtask

  task automatic test_bank_dup();
    set_f(0, 1, 3, 3); set_f(1, 2, 3, 3); set_f(2, 1, 3, 3);
    run_case(3, 0, "bank_dup");
  endtask

  task automatic test_unrepairable();
    for (int i = 0; i < 3; i++) begin
      set_f(i, 0, i + 1, i + 1);
      set_f(3 + 2 * i, 0, i + 1, 40 + i);
      set_f(4 + 2 * i, 0, 50 + i, i + 1);
    end
    run_case(9, 1, "unrepairable");
  endtask

  task automatic test_backpressure_reset();
    logic [SW-1:0] first;
    first = mk_word(1, 0, 1);
    pulse_start();
    fault_detect = 1'b1; bank_in = 2'd0; row_add_in = 10'd1; col_add_in = 10'd1;
    step();
    row_add_in = 10'd2; col_add_in = 10'd2; test_end = 1'b1;
    step();
    fault_detect = 1'b0; test_end = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (sol_valid !== 1'b1 || sol_data !== first) begin
        n_errors++;
        $display("FAIL hold_%0d: sv=%b sol_data=%h required 1 / %h", i, sol_valid, sol_data, first);
      end
      step();
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({early_term, sol_valid, done, repair} !== 4'b0000 || sol_data !== '0) begin
      n_errors++;
      $display("FAIL mid_report_reset: et/sv/done/repair=%b sol_data=%h required 0000 / 0",
               {early_term, sol_valid, done, repair}, sol_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        set_f(i, $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5));
      run_case(n, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ignore_idle();
    test_no_faults();
    test_single_row();
    test_pivot_overflow();
    test_bank_dup();
    test_unrepairable();
    test_backpressure_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bira_engine.md
BIRA_ENGINE -- requirements
Module: bira_engine

Parameters
REQ-001 SHALL have parameter ROW_W, default 10, row address width.
REQ-002 SHALL have parameter COL_W, default 10, column address width.
REQ-003 SHALL have parameter BANK_W, default 2, bank address width.
REQ-004 SHALL have parameter R_SPARES, default 2, spare rows; C_SPARES, default 2, spare columns.
REQ-005 SHALL have parameter NPCAM, default 8, non-pivot CAM depth; pivot CAM depth PCAM = R_SPARES + C_SPARES.

Interface
REQ-006 SHALL have: clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have: start  in  1  pulse, begins fault collection from IDLE.
REQ-009 SHALL have: fault_detect  in  1  fault address valid this cycle.
REQ-010 SHALL have: row_add_in  in  ROW_W; col_add_in  in  COL_W; bank_in  in  BANK_W  fault address.
REQ-011 SHALL have: test_end  in  1  BIST finished.
REQ-012 SHALL have: early_term  out  1  unrepairable, stop BIST.
REQ-013 SHALL have: sol_valid  out  1; sol_ready  in  1; sol_data  out  1+BANK_W+AW (AW = max(ROW_W,COL_W)) = {is_col, bank, zero-extended addr}.
REQ-014 SHALL have: done  out  1  analysis complete; repair  out  1  repairable, valid while done=1.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, ANALYZE, REPORT, DONE; IDLE->COLLECT on start.
REQ-016 In COLLECT, each fault_detect SHALL be classified in one cycle against stored entries of the same bank: exact match with a pivot or non-pivot -> dropped; row or col matches a pivot -> non-pivot CAM; otherwise -> pivot CAM.
REQ-017 New pivot when pivot CAM full, or new non-pivot when non-pivot CAM full, SHALL set early_term=1 the next cycle and go to DONE with repair=0.
REQ-018 fault_detect and test_end in the same cycle: the fault SHALL be classified first (REQ-016/017 apply), then COLLECT->ANALYZE unless early-terminated.
REQ-019 test_end with pivot count 0 SHALL go directly to DONE, repair=1, no solution words.
REQ-020 ANALYZE SHALL evaluate one candidate mask per cycle, mask = 0 .. 2^P-1 (P = pivot count), bit i=1 assigns pivot i a spare row, 0 a spare column.
REQ-021 Candidate valid iff popcount(mask) <= R_SPARES, P-popcount(mask) <= C_SPARES, and every non-pivot shares bank and row with a row-assigned pivot or bank and col with a column-assigned pivot.
REQ-022 First valid candidate (lowest mask) SHALL be latched and FSM -> REPORT next cycle; mask 2^P-1 invalid -> DONE, repair=0.
REQ-023 REPORT SHALL emit P words in pivot index order; row word = {0,bank,row}, column word = {1,bank,col}.
REQ-024 sol_valid SHALL hold with stable sol_data until sol_ready=1; word transfers on sol_valid & sol_ready; after last transfer -> DONE, repair=1, sol_valid=0.
REQ-025 fault_detect and test_end SHALL be ignored outside COLLECT; start ignored outside IDLE and DONE; start in DONE clears CAMs, done, repair, early_term and enters COLLECT.
REQ-026 Analysis latency SHALL be at most 2^PCAM+1 cycles from test_end to REPORT or DONE.
REQ-027 done SHALL be 1 only in DONE; early_term held until start or rst.

Reset
REQ-028 rst SHALL force IDLE, clear both CAM valid bits and counters, early_term=0, sol_valid=0, sol_data=0, done=0, repair=0.
REQ-029 rst SHALL take priority over all inputs in any state, including mid-ANALYZE and mid-REPORT handshake.

Verification
REQ-030 start; faults (b0,r5,c7),(b0,r5,c9); test_end -> pivot (r5,c7), non-pivot (r5,c9); mask 1 valid; one word {0,0,5}; done=1, repair=1.
REQ-031 Five faults, distinct rows/cols, bank 0 -> fifth fault sets early_term=1, done=1, repair=0.
REQ-032 Faults (b1,r3,c3),(b2,r3,c3) -> two pivots (banks differ); duplicate (b1,r3,c3) dropped; two words emitted.
REQ-033 Three pivots in rows 1,2,3 plus non-pivots sharing each pivot's row and column, test_end -> no mask satisfies REQ-021; DONE, repair=0.
REQ-034 sol_ready held 0 for 5 cycles in REPORT -> sol_valid and sol_data stable; rst asserted mid-REPORT -> IDLE, all outputs 0 next cycle.
REQ-035 test_end with no faults -> DONE, repair=1, sol_valid never asserted.
